// File: rtl/piece_collision_check.sv
// Collision test of a 4x4 piece against the playfield at a candidate position.
// The check scans the four piece rows in order. For each row it reads one board row word
// from synchronous RAM and tests the occupied cells against the walls, the floor and the stack.
//
// state | meaning
// IDLE  | waiting for start; collide holds the last result
// RD    | read strobe for piece row `row` is on the RAM port
// CHK   | board word for `row` is valid; OR this row's hits into collide
// FIN   | done pulse; result valid
module piece_collision_check #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int AW      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        block_matrix,
    input  logic [X_W-1:0]     pos_x,
    input  logic [Y_W-1:0]     pos_y,
    output logic               row_rd_en,
    output logic [AW-1:0]      row_rd_addr,
    input  logic [BOARD_W-1:0] row_rd_data,
    output logic               busy,
    output logic               done,
    output logic               collide
);

    typedef enum logic [1:0] {IDLE, RD, CHK, FIN} state_t;

    localparam logic signed [X_W:0] BW_X = (X_W+1)'(BOARD_W);
    localparam logic signed [Y_W:0] BH_Y = (Y_W+1)'(BOARD_H);

    state_t             state;
    logic [1:0]         row;
    logic [15:0]        matrix_q;
    logic [X_W-1:0]     px_q;
    logic [Y_W-1:0]     py_q;

    logic [15:0]        rd_m;
    logic [Y_W-1:0]     rd_py;
    logic [1:0]         rd_r;
    logic signed [Y_W:0] rd_y;
    logic               rd_go;

    logic signed [Y_W:0] y_cur;
    logic [3:0]         nib_cur;
    logic signed [X_W:0] x_c;
    logic [BOARD_W-1:0] shifted;
    logic               row_hit;

    function automatic logic [3:0] nibble(input logic [15:0] m, input logic [1:0] r);
        logic [3:0] n;
        case (r)
            2'd0:    n = m[15:12];
            2'd1:    n = m[11:8];
            2'd2:    n = m[7:4];
            default: n = m[3:0];
        endcase
        return n;
    endfunction

    function automatic logic signed [Y_W:0] row_y(input logic [Y_W-1:0] py, input logic [1:0] r);
        return $signed({py[Y_W-1], py}) + $signed({{(Y_W-1){1'b0}}, r});
    endfunction

    // Decide the next row read: row 0 straight from the inputs on an accepted start,
    // later rows from the latched query.
    always_comb begin
        rd_m  = matrix_q;
        rd_py = py_q;
        rd_r  = row + 2'd1;
        if (state == IDLE) begin
            rd_m  = block_matrix;
            rd_py = pos_y;
            rd_r  = 2'd0;
        end
        rd_y  = row_y(rd_py, rd_r);
        rd_go = (nibble(rd_m, rd_r) != 4'd0) && !rd_y[Y_W] && (rd_y < BH_Y);
    end

    // Collision test of the current piece row against walls, floor and the board word.
    always_comb begin
        y_cur   = row_y(py_q, row);
        nib_cur = nibble(matrix_q, row);
        row_hit = 1'b0;
        x_c     = '0;
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            x_c     = $signed({px_q[X_W-1], px_q}) + $signed({{(X_W-1){1'b0}}, c[1:0]});
            shifted = row_rd_data >> x_c;
            if (nib_cur[3-c]) begin
                if (x_c[X_W] || (x_c >= BW_X))
                    row_hit = 1'b1;
                else if (y_cur >= BH_Y)
                    row_hit = 1'b1;
                else if (!y_cur[Y_W] && shifted[0])
                    row_hit = 1'b1;
            end
        end
    end

    // Sequencer with registered outputs. A start that arrives outside IDLE is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= 2'd0;
            matrix_q    <= '0;
            px_q        <= '0;
            py_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            collide     <= 1'b0;
            row_rd_en   <= 1'b0;
            row_rd_addr <= '0;
        end else begin
            row_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        matrix_q <= block_matrix;
                        px_q     <= pos_x;
                        py_q     <= pos_y;
                        collide  <= 1'b0;
                        busy     <= 1'b1;
                        row      <= 2'd0;
                        state    <= RD;
                        if (rd_go) begin
                            row_rd_en   <= 1'b1;
                            row_rd_addr <= rd_y[AW-1:0];
                        end
                    end
                end
                RD: state <= CHK;
                CHK: begin
                    if (row_hit)
                        collide <= 1'b1;
                    if (row == 2'd3) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        row   <= row + 2'd1;
                        state <= RD;
                        if (rd_go) begin
                            row_rd_en   <= 1'b1;
                            row_rd_addr <= rd_y[AW-1:0];
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_collision_check.sv
// Bench for piece_collision_check: a board RAM model, plus queued expected reads and results
// that are matched against the DUT's read strobes and done pulses.
module tb_piece_collision_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] block_matrix = '0;
    logic [5:0]  pos_x = '0;
    logic [5:0]  pos_y = '0;
    logic        row_rd_en;
    logic [4:0]  row_rd_addr;
    logic [9:0]  row_rd_data = '0;
    logic        busy;
    logic        done;
    logic        collide;

    logic [9:0]  board [0:31];
    int          cyc = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          rd_k_q[$];
    int          rd_a_q[$];
    int          res_q[$];

    piece_collision_check dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_matrix(block_matrix),
        .pos_x(pos_x), .pos_y(pos_y), .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr),
        .row_rd_data(row_rd_data), .busy(busy), .done(done), .collide(collide)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (row_rd_en) row_rd_data <= board[row_rd_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Match read strobes and done pulses against the queued expectations.
    always @(negedge clk) begin
        int k;
        k = cyc - t0 + 1;
        if (row_rd_en) begin
            if (rd_k_q.size() == 0) check("spurious_rd", 1, 0);
            else begin
                check("rd_cyc", k, rd_k_q.pop_front());
                check("rd_addr", int'(row_rd_addr), rd_a_q.pop_front());
            end
        end
        if (done) begin
            check("done_cyc", k, 9);
            if (res_q.size() == 0) check("spurious_done", 1, 0);
            else check("collide", int'(collide), res_q.pop_front());
        end
    end

    function automatic int model(input logic [15:0] m, input int x, input int y);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[15-4*r-c]) begin
                    if (x + c < 0 || x + c >= 10 || y + r >= 20) return 1;
                    if (y + r >= 0 && board[y+r][x+c]) return 1;
                end
        return 0;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 32; i++) board[i] = '0;
    endtask

    // mode 0: plain query; 1: extra start in cycle 4; 2: reset in cycle 5
    task automatic run(input logic [15:0] m, input int x, input int y, input int exp, input int mode);
        logic [15:0] mm;
        mm = m;
        for (int r = 0; r < 4; r++) begin
            if (((mm >> (12 - 4*r)) & 16'hF) != 0 && y + r >= 0 && y + r < 20
                && !(mode == 2 && 1 + 2*r > 5)) begin
                rd_k_q.push_back(1 + 2*r);
                rd_a_q.push_back(y + r);
            end
        end
        if (mode != 2) res_q.push_back(exp);
        block_matrix = m;
        pos_x = 6'(x);
        pos_y = 6'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        block_matrix = 16'($urandom);
        pos_x = 6'($urandom);
        pos_y = 6'($urandom);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_c1", int'(busy), 1);
            if (mode == 1 && k == 4) start = 1'b1;
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 5) rst_n = 1'b0;
            if (mode == 2 && k == 6) begin
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_collide", int'(collide), 0);
                check("rst_rd_en", int'(row_rd_en), 0);
                rst_n = 1'b1;
            end
            if (k == 10 && mode != 2) begin
                check("busy_c10", int'(busy), 0);
                check("collide_hold", int'(collide), exp);
            end
        end
        check("reads_left", rd_k_q.size(), 0);
        check("results_left", res_q.size(), 0);
        rd_k_q.delete();
        rd_a_q.delete();
        res_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear_board();
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_collide", int'(collide), 0);
        check("reset_rd_en", int'(row_rd_en), 0);
        check("reset_addr", int'(row_rd_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'h2222, 0, 0, 0, 0);
        run(16'h0660, -1, 0, 0, 0);
        run(16'h0660, -2, 0, 1, 0);
        run(16'h0660, 8, 0, 1, 0);
        run(16'h2222, 0, 17, 1, 0);
        board[19] = 10'b0000010000;
        run(16'h0660, 3, 17, 1, 0);
        run(16'h0660, 5, 17, 0, 0);
        clear_board();
        run(16'h2222, 0, -3, 0, 0);
        board[0][2] = 1'b1;
        run(16'h2222, 0, -3, 1, 0);
        run(16'h0000, 3, 5, 0, 0);
        clear_board();
        run(16'h2222, 0, 0, 0, 1);
        run(16'h2222, 0, 0, 0, 2);
        repeat (12) @(negedge clk);
        check("no_done_after_rst", res_q.size(), 0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] m;
            int x, y;
            for (int r = 0; r < 20; r++) board[r] = 10'($urandom) & 10'($urandom);
            m = 16'($urandom);
            x = int'($urandom_range(0, 14)) - 3;
            y = int'($urandom_range(0, 25)) - 4;
            run(m, x, y, model(m, x, y), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
